// File: rtl/dram_emu.sv
// rtl/dram_emu.sv - behavioural DRAM emulator with RAS/CAS protocol, page mode, RMW and CBR refresh
module dram_emu #(
  parameter int ADDR_BITS = 8,
  parameter int DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] IDLE_DATA = {DATA_WIDTH{1'b1}}
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_BITS-1:0]  address,
  input  logic                  ras,
  input  logic                  cas,
  input  logic                  rw,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic [15:0]           refresh_count,
  output logic                  protocol_err
);

  localparam int IDX_BITS   = 2 * ADDR_BITS;
  localparam int BANK_DEPTH = 2 ** (IDX_BITS - 1);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_ROW_OPEN   = 3'd1;
  localparam logic [2:0] S_COL_ACTIVE = 3'd2;
  localparam logic [2:0] S_CBR_WAIT   = 3'd3;
  localparam logic [2:0] S_REFRESH    = 3'd4;

  logic [2:0] state;

  // Previous strobe samples plus "armed" flags: a strobe held low through
  // reset release must be seen high once before it can produce a fall.
  logic ras_q, cas_q, rw_q;
  logic ras_arm, cas_arm, rw_arm;
  logic ras_fall, cas_fall, rw_fall;
  logic ras_rise, cas_rise;

  logic [ADDR_BITS-1:0] row_q;
  logic [ADDR_BITS-1:0] col_q;

  // The array is split by index LSB (= row LSB) so each bank has a single
  // uniform power-up value: even words clear, odd words all ones.
  logic [DATA_WIDTH-1:0] mem_even [BANK_DEPTH] = '{default: {DATA_WIDTH{1'b0}}};
  logic [DATA_WIDTH-1:0] mem_odd  [BANK_DEPTH] = '{default: {DATA_WIDTH{1'b1}}};

  logic [IDX_BITS-1:0]   acc_idx;
  logic [IDX_BITS-1:0]   wr_idx;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] rd_word;

  assign ras_fall = ras_arm & ras_q & ~ras;
  assign cas_fall = cas_arm & cas_q & ~cas;
  assign rw_fall  = rw_arm & rw_q & ~rw;
  assign ras_rise = ~ras_q & ras;
  assign cas_rise = ~cas_q & cas;

  // Column access index for a cas fall: column from the bus, row from the latch.
  assign acc_idx = {address, row_q};

  // Strobe sampling and arming for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      ras_q   <= 1'b1;
      cas_q   <= 1'b1;
      rw_q    <= 1'b1;
      ras_arm <= 1'b0;
      cas_arm <= 1'b0;
      rw_arm  <= 1'b0;
    end else begin
      ras_q   <= ras;
      cas_q   <= cas;
      rw_q    <= rw;
      ras_arm <= ras_arm | ras;
      cas_arm <= cas_arm | cas;
      rw_arm  <= rw_arm | rw;
    end
  end

  // Write enable and target: early write on the cas fall, late write on rw fall.
  always_comb begin
    wr_en  = 1'b0;
    wr_idx = acc_idx;
    if (!reset) begin
      if (state == S_ROW_OPEN && !ras_rise && cas_fall && !rw) begin
        wr_en  = 1'b1;
        wr_idx = acc_idx;
      end else if (state == S_COL_ACTIVE && !ras_rise && !cas_rise && rw_fall && !cas) begin
        wr_en  = 1'b1;
        wr_idx = {col_q, row_q};
      end
    end
  end

  // Asynchronous bank select for the read word captured on a read cas fall.
  always_comb begin
    rd_word = acc_idx[0] ? mem_odd[acc_idx[IDX_BITS-1:1]] : mem_even[acc_idx[IDX_BITS-1:1]];
  end

  // Array write port; deliberately untouched by reset so contents survive it.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (wr_idx[0]) begin
        mem_odd[wr_idx[IDX_BITS-1:1]] <= data_in;
      end else begin
        mem_even[wr_idx[IDX_BITS-1:1]] <= data_in;
      end
    end
  end

  // Protocol state machine, read data register, refresh counter and error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      data_valid    <= 1'b0;
      data_out      <= IDLE_DATA;
      refresh_count <= 16'd0;
      protocol_err  <= 1'b0;
      row_q         <= '0;
      col_q         <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (ras_fall && cas) begin
            row_q <= address;
            state <= S_ROW_OPEN;
          end else if (ras_fall && cas_fall) begin
            // Row still opens, but the column needs its own later cas fall.
            row_q        <= address;
            protocol_err <= 1'b1;
            state        <= S_ROW_OPEN;
          end else if (cas_fall && ras) begin
            state <= S_CBR_WAIT;
          end
        end
        S_ROW_OPEN: begin
          if (ras_rise) begin
            state <= S_IDLE;
          end else if (cas_fall) begin
            col_q <= address;
            state <= S_COL_ACTIVE;
            if (rw) begin
              data_valid <= 1'b1;
              data_out   <= rd_word;
            end
          end
        end
        S_COL_ACTIVE: begin
          if (ras_rise) begin
            state      <= S_IDLE;
            data_valid <= 1'b0;
            data_out   <= IDLE_DATA;
          end else if (cas_rise) begin
            state      <= S_ROW_OPEN;
            data_valid <= 1'b0;
            data_out   <= IDLE_DATA;
          end else if (rw_fall) begin
            // Read-modify-write: the old word is no longer meaningful.
            data_valid <= 1'b0;
            data_out   <= IDLE_DATA;
          end
        end
        S_CBR_WAIT: begin
          if (ras_fall) begin
            state         <= S_REFRESH;
            refresh_count <= refresh_count + 16'd1;
          end else if (cas_rise) begin
            state <= S_IDLE;
          end
        end
        S_REFRESH: begin
          if (ras_rise) begin
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dram_emu.sv
// tb/tb_dram_emu.sv - transaction-level model checking of dram_emu
module tb_dram_emu;
  localparam int AB = 8;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [AB-1:0] address;
  logic          ras, cas, rw;
  logic [DW-1:0] data_in;
  logic [DW-1:0] data_out;
  logic          data_valid;
  logic [15:0]   refresh_count;
  logic          protocol_err;

  dram_emu #(.ADDR_BITS(AB), .DATA_WIDTH(DW), .IDLE_DATA(8'hFF)) dut (
    .clk(clk), .reset(reset), .address(address), .ras(ras), .cas(cas), .rw(rw),
    .data_in(data_in), .data_out(data_out), .data_valid(data_valid),
    .refresh_count(refresh_count), .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  bit          chk_en = 1'b0;
  logic        exp_valid;
  logic [7:0]  exp_data;
  logic [15:0] exp_cnt;
  logic        exp_err;

  // Model array: only written words are stored; others take the power-up pattern.
  logic [7:0] mm [int];

  function automatic int idx_of(input logic [7:0] row, input logic [7:0] col);
    return int'(col) * 256 + int'(row);
  endfunction

  function automatic logic [7:0] mget(input int idx);
    if (mm.exists(idx)) return mm[idx];
    return (idx % 2 == 1) ? 8'hFF : 8'h00;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("data_valid", 32'(data_valid), 32'(exp_valid));
      check("data_out", 32'(data_out), exp_valid ? 32'(exp_data) : 32'hFF);
      check("refresh_count", 32'(refresh_count), 32'(exp_cnt));
      check("protocol_err", 32'(protocol_err), 32'(exp_err));
    end
  end

  task automatic drive(input logic r, input logic c, input logic w,
                       input logic [7:0] a, input logic [7:0] d);
    ras = r; cas = c; rw = w; address = a; data_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic open_row(input logic [7:0] row);
    drive(1'b0, 1'b1, 1'b1, row, 8'($urandom));
    exp_valid = 1'b0;
  endtask

  task automatic close_row();
    drive(1'b1, 1'b1, 1'b1, 8'($urandom), 8'($urandom));
    exp_valid = 1'b0;
  endtask

  task automatic cas_up();
    drive(1'b0, 1'b1, 1'b1, 8'($urandom), 8'($urandom));
    exp_valid = 1'b0;
  endtask

  task automatic rd(input logic [7:0] row, input logic [7:0] col, input int hold,
                    output logic [7:0] got);
    drive(1'b0, 1'b0, 1'b1, col, 8'($urandom));
    exp_valid = 1'b1;
    exp_data  = mget(idx_of(row, col));
    got = data_out;
    for (int h = 0; h < hold; h++) drive(1'b0, 1'b0, 1'b1, 8'($urandom), 8'($urandom));
  endtask

  task automatic wr(input logic [7:0] row, input logic [7:0] col, input logic [7:0] d);
    drive(1'b0, 1'b0, 1'b0, col, d);
    mm[idx_of(row, col)] = d;
    exp_valid = 1'b0;
    cas_up();
  endtask

  task automatic rmw(input logic [7:0] row, input logic [7:0] col, input logic [7:0] d);
    logic [7:0] got;
    rd(row, col, 1, got);
    drive(1'b0, 1'b0, 1'b0, 8'($urandom), d);
    mm[idx_of(row, col)] = d;
    exp_valid = 1'b0;
    cas_up();
  endtask

  task automatic cbr();
    drive(1'b1, 1'b0, 1'b1, 8'($urandom), 8'($urandom));
    drive(1'b0, 1'b0, 1'b1, 8'($urandom), 8'($urandom));
    exp_cnt = exp_cnt + 16'd1;
    drive(1'b1, 1'b0, 1'b1, 8'($urandom), 8'($urandom));
    drive(1'b1, 1'b1, 1'b1, 8'($urandom), 8'($urandom));
  endtask

  task automatic cbr_abort();
    drive(1'b1, 1'b0, 1'b1, 8'($urandom), 8'($urandom));
    drive(1'b1, 1'b1, 1'b1, 8'($urandom), 8'($urandom));
  endtask

  initial begin
    logic [7:0] got;
    logic [7:0] r, c;
    reset = 1'b1;
    exp_valid = 1'b0; exp_data = 8'hFF; exp_cnt = 16'd0; exp_err = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 8'h00, 8'h00);
    drive(1'b1, 1'b1, 1'b1, 8'h00, 8'h00);
    chk_en = 1'b1;
    check("reset_data_out", 32'(data_out), 32'hFF);
    check("reset_count", 32'(refresh_count), 32'h0);
    reset = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 8'h00, 8'h00);

    // Power-up pattern: even index reads 0x00, odd index reads 0xFF.
    open_row(8'h02); rd(8'h02, 8'h00, 1, got); cas_up(); close_row();
    check("pwrup_even", 32'(got), 32'h00);
    open_row(8'h03); rd(8'h03, 8'h00, 1, got); cas_up(); close_row();
    check("pwrup_odd", 32'(got), 32'hFF);

    // Early write then read back with one cycle latency.
    open_row(8'h12); wr(8'h12, 8'h34, 8'hA5);
    rd(8'h12, 8'h34, 2, got);
    check("early_wr_data", 32'(got), 32'hA5);
    check("early_wr_valid", 32'(data_valid), 32'h1);
    cas_up(); close_row();

    // Page mode: four writes and four reads, each under a single RAS low.
    open_row(8'h40);
    for (int k = 0; k < 4; k++) wr(8'h40, 8'(k), 8'(8'h10 + k));
    close_row();
    open_row(8'h40);
    for (int k = 0; k < 4; k++) begin
      rd(8'h40, 8'(k), 0, got);
      check("page_rd", 32'(got), 32'(8'h10 + k));
      cas_up();
    end
    close_row();

    // Read-modify-write.
    open_row(8'h12);
    rd(8'h12, 8'h34, 1, got);
    check("rmw_old", 32'(got), 32'hA5);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h5A);
    mm[idx_of(8'h12, 8'h34)] = 8'h5A;
    exp_valid = 1'b0;
    check("rmw_valid_drop", 32'(data_valid), 32'h0);
    cas_up(); close_row();
    open_row(8'h12); rd(8'h12, 8'h34, 0, got); cas_up(); close_row();
    check("rmw_new", 32'(got), 32'h5A);

    // CBR refresh and abort.
    cbr(); cbr(); cbr();
    check("cbr_count3", 32'(refresh_count), 32'h3);
    cbr_abort();
    check("cbr_abort_count", 32'(refresh_count), 32'h3);
    open_row(8'h12); rd(8'h12, 8'h34, 0, got); cas_up(); close_row();
    check("cbr_array_kept", 32'(got), 32'h5A);

    // Randomized traffic against the model.
    for (int t = 0; t < 150; t++) begin
      case ($urandom_range(0, 5))
        0: cbr();
        1: cbr_abort();
        default: begin
          r = 8'($urandom);
          open_row(r);
          for (int a = 0; a < int'($urandom_range(1, 3)); a++) begin
            c = 8'($urandom);
            case ($urandom_range(0, 2))
              0: begin rd(r, c, $urandom_range(0, 2), got); cas_up(); end
              1: wr(r, c, 8'($urandom));
              default: rmw(r, c, 8'($urandom));
            endcase
          end
          close_row();
        end
      endcase
    end

    // Simultaneous ras/cas fall: row opens with error, column needs a later cas fall.
    drive(1'b0, 1'b0, 1'b1, 8'h77, 8'h00);
    exp_err = 1'b1; exp_valid = 1'b0;
    check("simul_err", 32'(protocol_err), 32'h1);
    check("simul_no_access", 32'(data_valid), 32'h0);
    cas_up();
    rd(8'h77, 8'h01, 0, got);
    check("simul_later_rd", 32'(got), 32'hFF);
    cas_up(); close_row();

    // Reset mid-access with a pending rw fall, strobes held low afterwards.
    open_row(8'h55); wr(8'h55, 8'h66, 8'h3C);
    rd(8'h55, 8'h66, 0, got);
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'hC3);
    exp_valid = 1'b0; exp_cnt = 16'd0; exp_err = 1'b0;
    check("rst_mid_valid", 32'(data_valid), 32'h0);
    check("rst_mid_err", 32'(protocol_err), 32'h0);
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    drive(1'b1, 1'b1, 1'b1, 8'h00, 8'h00);
    open_row(8'h55); rd(8'h55, 8'h66, 0, got); cas_up(); close_row();
    check("rst_data_survives", 32'(got), 32'h3C);

    for (int t = 0; t < 30; t++) begin
      r = 8'($urandom); c = 8'($urandom);
      open_row(r); wr(r, c, 8'($urandom)); rd(r, c, 1, got); cas_up(); close_row();
      if (t % 10 == 0) cbr();
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
